// File: rtl/expansion_key_mix_if.sv
// Handshake bundle between the round controller, the expansion/key-mix stage
// and the S-box/P-permutation path.
interface expansion_key_mix_if #(
  parameter int unsigned ROUND_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        right_half;
  logic [47:0]        subkey;
  logic [ROUND_W-1:0] round_in;
  logic               out_valid;
  logic               out_ready;
  logic [47:0]        s_box_inputs;
  logic [ROUND_W-1:0] round_out;

  modport master (
    output in_valid, right_half, subkey, round_in, out_ready,
    input  in_ready, out_valid, s_box_inputs, round_out
  );

  modport slave (
    input  in_valid, right_half, subkey, round_in, out_ready,
    output in_ready, out_valid, s_box_inputs, round_out
  );
endinterface

// File: rtl/expansion_key_mix.sv
// DES E expansion XOR round subkey, held in a 2-entry elastic buffer that feeds
// the eight S-boxes (S-box 7 reads s_box_inputs[11:6]).
module expansion_key_mix #(
  parameter int unsigned ROUND_W = 4
) (
  input logic                clk,
  input logic                reset,
  expansion_key_mix_if.slave bus
);

  localparam int unsigned R_W    = 32;
  localparam int unsigned DATA_W = 48;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 2;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [ROUND_W-1:0] tag;
  } entry_t;

  // E table in closed form: group g, position j selects R bit 4g+j, wrapping 0->32 and 33->1.
  function automatic logic [DATA_W-1:0] e_expand(input logic [R_W-1:0] r);
    logic [DATA_W-1:0] e;
    int unsigned       n;
    int unsigned       m;
    e = '0;
    for (int unsigned g = 0; g < 8; g++) begin
      for (int unsigned j = 0; j < 6; j++) begin
        n = 4 * g + j;
        if (n == 0) n = 32;
        else if (n == 33) n = 1;
        m = 6 * g + j + 1;
        e[6'(DATA_W - m)] = r[5'(R_W - n)];
      end
    end
    return e;
  endfunction

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             accept_c;
  logic             pop_c;
  entry_t           new_entry_c;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    accept_c    = bus.in_valid & in_ready_q;
    pop_c       = out_valid_q & bus.out_ready;
    new_entry_c = '{data: e_expand(bus.right_half) ^ bus.subkey, tag: bus.round_in};

    if (accept_c) begin
      mem_d[wr_ptr_q] = new_entry_c;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_c) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({accept_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Flags come from next-state count so in_ready never sees out_ready combinationally.
    in_ready_d  = (count_d != CNT_W'(DEPTH));
    out_valid_d = (count_d != CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.s_box_inputs = mem_q[rd_ptr_q].data;
  assign bus.round_out    = mem_q[rd_ptr_q].tag;

endmodule

// File: tb/tb_expansion_key_mix.sv
// Directed bench for expansion_key_mix: known-answer vectors plus handshake,
// backpressure, pointer-wrap and mid-stream reset sequences.
module tb_expansion_key_mix;

  localparam int unsigned ROUND_W = 4;

  logic clk;
  logic reset;

  expansion_key_mix_if #(.ROUND_W(ROUND_W)) bus ();

  expansion_key_mix #(.ROUND_W(ROUND_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]        r;
    logic [47:0]        k;
    logic [ROUND_W-1:0] tag;
    logic [47:0]        exp;
  } vec_t;

  vec_t vecs [6];
  int   passed;
  int   total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [47:0] k,
                       input logic [ROUND_W-1:0] tag);
    bus.in_valid   = v;
    bus.right_half = r;
    bus.subkey     = k;
    bus.round_in   = tag;
  endtask

  initial begin
    passed = 0;
    total  = 0;

    vecs[0] = '{r: 32'h00000000, k: 48'h000000000000, tag: 4'd3,  exp: 48'h000000000000};
    vecs[1] = '{r: 32'h00000001, k: 48'h000000000000, tag: 4'd4,  exp: 48'h800000000002};
    vecs[2] = '{r: 32'hF0AAF0AA, k: 48'h1B02EFFC7072, tag: 4'd5,  exp: 48'h6117BA866527};
    vecs[3] = '{r: 32'h80000000, k: 48'h000000000000, tag: 4'd6,  exp: 48'h400000000001};
    vecs[4] = '{r: 32'hFFFFFFFF, k: 48'h000000000000, tag: 4'd7,  exp: 48'hFFFFFFFFFFFF};
    vecs[5] = '{r: 32'h00000000, k: 48'hA5A5A5A5A5A5, tag: 4'd15, exp: 48'hA5A5A5A5A5A5};

    reset         = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 48'h0, 4'd0);
    @(negedge clk);
    step();
    reset = 1'b0;

    check("rst_in_ready",  64'(bus.in_ready),     64'd1);
    check("rst_out_valid", 64'(bus.out_valid),    64'd0);
    check("rst_sbox",      64'(bus.s_box_inputs), 64'd0);
    check("rst_round",     64'(bus.round_out),    64'd0);

    // One entry at a time through an empty buffer: 1-cycle latency, no bypass.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].r, vecs[i].k, vecs[i].tag);
      check($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
      check($sformatf("vec%0d_no_bypass", i), 64'(bus.out_valid), 64'd0);
      step();
      drive(1'b0, 32'h0, 48'h0, 4'd0);
      check($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid),    64'd1);
      check($sformatf("vec%0d_sbox", i),      64'(bus.s_box_inputs), 64'(vecs[i].exp));
      check($sformatf("vec%0d_round", i),     64'(bus.round_out),    64'(vecs[i].tag));
      if (i == 2) check("kat_sbox7_slice", 64'(bus.s_box_inputs[11:6]), 64'(6'b010100));
      step();
      check($sformatf("vec%0d_drained", i), 64'(bus.out_valid), 64'd0);
    end

    // Backpressure: tags 1,2 fill the buffer, tag 3 waits.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00000001, 48'h0, 4'd1);
    step();
    check("bp_in_ready_c1", 64'(bus.in_ready),  64'd1);
    check("bp_head_c1",     64'(bus.round_out), 64'd1);
    drive(1'b1, 32'h0, 48'h000000000002, 4'd2);
    step();
    check("bp_in_ready_full", 64'(bus.in_ready),  64'd0);
    check("bp_out_valid",     64'(bus.out_valid), 64'd1);
    drive(1'b1, 32'h0, 48'h000000000003, 4'd3);
    step();
    check("bp_in_ready_hold", 64'(bus.in_ready),     64'd0);
    check("bp_head_hold",     64'(bus.round_out),    64'd1);
    check("bp_data_hold",     64'(bus.s_box_inputs), 64'(48'h800000000002));
    // Pop while full: in_ready stays low this cycle, rises next.
    bus.out_ready = 1'b1;
    check("bp_full_pop_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    check("bp_after_pop_in_ready", 64'(bus.in_ready),     64'd1);
    check("bp_drain_tag2",         64'(bus.round_out),    64'd2);
    check("bp_drain_data2",        64'(bus.s_box_inputs), 64'(48'h000000000002));
    // Count 1 with accept and pop together: head moves to tag 3.
    step();
    drive(1'b0, 32'h0, 48'h0, 4'd0);
    check("bp_simul_out_valid", 64'(bus.out_valid),    64'd1);
    check("bp_drain_tag3",      64'(bus.round_out),    64'd3);
    check("bp_drain_data3",     64'(bus.s_box_inputs), 64'(48'h000000000003));
    step();
    check("bp_empty", 64'(bus.out_valid), 64'd0);

    // Continuous stream at full throughput, wrapping both pointers several times.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'h0, 48'h111111111111 * 48'(i + 1), 4'(i + 8));
      check($sformatf("st%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
      step();
      check($sformatf("st%0d_round", i), 64'(bus.round_out), 64'(i + 8));
      check($sformatf("st%0d_sbox", i),  64'(bus.s_box_inputs),
            64'(48'h111111111111 * 48'(i + 1)));
    end
    drive(1'b0, 32'h0, 48'h0, 4'd0);
    step();
    check("st_empty", 64'(bus.out_valid), 64'd0);

    // Mid-stream reset with an entry presented during reset.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072, 4'd7);
    step();
    drive(1'b1, 32'h00000001, 48'h0, 4'd8);
    step();
    check("mr_full", 64'(bus.in_ready), 64'd0);
    reset = 1'b1;
    drive(1'b1, 32'hFFFFFFFF, 48'h0, 4'd9);
    bus.out_ready = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0, 48'h0, 4'd0);
    check("mr_out_valid", 64'(bus.out_valid),    64'd0);
    check("mr_in_ready",  64'(bus.in_ready),     64'd1);
    check("mr_sbox",      64'(bus.s_box_inputs), 64'd0);
    check("mr_round",     64'(bus.round_out),    64'd0);
    step();
    check("mr_not_stored", 64'(bus.out_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/expansion_key_mix.md
# expansion_key_mix

Registered expansion/key-mix stage directly upstream of the eight DES S-boxes. It accepts a 32-bit right half and a 48-bit round subkey, applies the DES E expansion, XORs with the subkey, and holds the 48-bit result in a 2-entry elastic buffer. Each S-box, including `s_box_seven`, takes its 6-bit slice from that buffer. The valid/ready handshake on both sides lets the round controller and the S-box/P-permutation path stall independently without losing data.

## Interface
- `ROUND_W`, default 4: width of the round tag carried alongside each entry.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `right_half`, `subkey` and `round_in` are valid this cycle.
- `in_ready`  out  1  stage can accept an entry this cycle.
- `right_half`  in  32  R input; bit [31] is DES bit 1, bit [0] is DES bit 32.
- `subkey`  in  48  K input; bit [47] is DES bit 1.
- `round_in`  in  ROUND_W  round tag, passed through unmodified.
- `out_valid`  out  1  `s_box_inputs` and `round_out` are valid.
- `out_ready`  in  1  downstream consumes the head entry this cycle.
- `s_box_inputs`  out  48  E(R) XOR K. Slice [47:42] feeds S-box 1, and each following box takes the next 6 bits down. S-box 7 takes [11:6]; S-box 8 takes [5:0].
- `round_out`  out  ROUND_W  tag of the head entry.

## Operation
- Expansion, using DES 1-based numbering: output bit m equals R bit E[m].
- E table, in groups of 6:
  - 32 1 2 3 4 5
  - 4 5 6 7 8 9
  - 8 9 10 11 12 13
  - 12 13 14 15 16 17
  - 16 17 18 19 20 21
  - 20 21 22 23 24 25
  - 24 25 26 27 28 29
  - 28 29 30 31 32 1
- Index mapping: R bit n is `right_half[32-n]`; output bit m is `s_box_inputs[48-m]`.
- Mix: entry data is the expansion XORed bitwise with `subkey`. The mix is computed combinationally at the input and stored already mixed.
- Buffer: 2 entries, each holding 48 data bits plus ROUND_W tag bits. It is FIFO-ordered, using a 1-bit write pointer, a 1-bit read pointer and a 2-bit count.
- Accept: `in_valid & in_ready` writes the entry at the write pointer and toggles the pointer.
- Pop: `out_valid & out_ready` toggles the read pointer.
- Count: increments on accept only, decrements on pop only, and is unchanged when both happen in the same cycle.
- `in_ready` is `count != 2`. It is registered-state derived only and has no combinational path from `out_ready`.
- `out_valid` is `count != 0`.
- `s_box_inputs` and `round_out` come from the entry at the read pointer.
- Full (count 2) with `out_ready` high: the pop occurs and `in_ready` stays low that cycle. A new entry is accepted from the next cycle onward.
- Empty (count 0): an accepted entry appears on the outputs the next cycle. There is no bypass.
- Output data is held stable while `out_valid & ~out_ready`.
- Reset, including mid-operation:
  - count and both pointers clear to 0.
  - `in_ready` becomes 1 and `out_valid` becomes 0.
  - Storage data clears to 0, so `s_box_inputs` is 0 and `round_out` is 0.
  - Any entries in flight are discarded.
  - Reset takes priority over a simultaneous accept or pop.

## Timing
- Latency from accept to `out_valid` is 1 cycle.
- Throughput is 1 entry per cycle when `out_ready` is held high.
- Reset values: `in_ready`=1, `out_valid`=0, `s_box_inputs`=48'h0, `round_out`=0.
- Two consecutive accepts with `out_ready` low give count 2, and `in_ready` goes low on the following cycle.
- With a wrap-around of 1-bit pointers, ordering is preserved across an indefinite stream.

## Test plan
- Reset, then zero input: R=0, K=0, tag 3 -> the next cycle shows `out_valid`=1, `s_box_inputs`=48'h0, `round_out`=3.
- Expansion wrap bits: R=32'h00000001, K=0 -> `s_box_inputs`=48'h800000000002.
- DES known answer: R=32'hF0AAF0AA, K=48'h1B02EFFC7072 -> `s_box_inputs`=48'h6117BA866527, and slice [11:6]=6'b010100 goes to S-box 7.
- Backpressure: three entries with tags 1, 2, 3 and `out_ready`=0 -> tags 1 and 2 are accepted, `in_ready`=0 while tag 3 is held. Raising `out_ready` drains tags 1, 2, 3 in order with no loss and no duplication.
- Simultaneous events: count 1 with accept and pop in the same cycle -> count stays 1 and the head advances to the new entry. Count 2 with pop -> `in_ready` is 0 that cycle and 1 on the next.
- Mid-stream reset: count 2, then assert `reset` for 1 cycle with `in_valid`=1 -> after reset `out_valid`=0, `in_ready`=1 and outputs are 0. The entry presented during reset is not stored.
